// File: rtl/cmdq_dispatch.sv
// Read side of the command storage queue: pops one command at a time,
// presents it to the engine and tracks outstanding credits and completions.
module cmdq_dispatch #(
  parameter int CMD_DATA_WIDTH  = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clock_fpga,
  input  logic                      reset,
  input  logic                      sq_empty,
  output logic                      sq_rd_en,
  input  logic [CMD_DATA_WIDTH-1:0] sq_rd_data,
  input  logic [7:0]                sq_rd_index,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [CMD_DATA_WIDTH-1:0] cmd_out,
  output logic [7:0]                cmd_index,
  input  logic                      done_valid,
  input  logic [7:0]                done_index,
  input  logic [7:0]                done_status,
  output logic                      status_update_enable,
  output logic [7:0]                status_index,
  output logic [7:0]                status_code,
  output logic [3:0]                outstanding,
  output logic                      underflow_err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LATCH,
    PRESENT
  } state_t;

  state_t state;

  logic accept;
  logic credit_ok;
  logic none_out;

  assign sq_rd_en  = (state == FETCH);
  assign cmd_valid = (state == PRESENT);
  assign accept    = cmd_valid & cmd_ready;
  assign credit_ok = (outstanding < 4'(MAX_OUTSTANDING));
  assign none_out  = (outstanding == 4'd0);

  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_out   <= '0;
      cmd_index <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!sq_empty && credit_ok)
            state <= FETCH;
        end
        FETCH: state <= LATCH;
        LATCH: begin
          cmd_out   <= sq_rd_data;
          cmd_index <= sq_rd_index;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (cmd_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue and completion in the same cycle cancel out.
  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      outstanding   <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (accept && !done_valid) begin
        if (outstanding != 4'hF)
          outstanding <= outstanding + 4'd1;
      end else if (done_valid && !accept && !none_out) begin
        outstanding <= outstanding - 4'd1;
      end
      if (done_valid && none_out)
        underflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      status_update_enable <= 1'b0;
      status_index         <= '0;
      status_code          <= '0;
    end else begin
      status_update_enable <= done_valid;
      if (done_valid) begin
        status_index <= done_index;
        status_code  <= done_status;
      end
    end
  end

endmodule

// File: tb/tb_cmdq_dispatch.sv
// Directed bench for cmdq_dispatch with a small storage-queue model
// and a table of completion-path vectors.
module tb_cmdq_dispatch;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sq_empty;
  logic         sq_rd_en;
  logic [W-1:0] sq_rd_data = '0;
  logic [7:0]   sq_rd_index = '0;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_out;
  logic [7:0]   cmd_index;
  logic         done_valid;
  logic [7:0]   done_index;
  logic [7:0]   done_status;
  logic         status_update_enable;
  logic [7:0]   status_index;
  logic [7:0]   status_code;
  logic [3:0]   outstanding;
  logic         underflow_err;

  always #5 clk = ~clk;

  cmdq_dispatch #(
    .CMD_DATA_WIDTH (W),
    .MAX_OUTSTANDING(8)
  ) dut (
    .clock_fpga          (clk),
    .reset               (rst_n),
    .sq_empty            (sq_empty),
    .sq_rd_en            (sq_rd_en),
    .sq_rd_data          (sq_rd_data),
    .sq_rd_index         (sq_rd_index),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_out             (cmd_out),
    .cmd_index           (cmd_index),
    .done_valid          (done_valid),
    .done_index          (done_index),
    .done_status         (done_status),
    .status_update_enable(status_update_enable),
    .status_index        (status_index),
    .status_code         (status_code),
    .outstanding         (outstanding),
    .underflow_err       (underflow_err)
  );

  // Storage queue model: data appears the cycle after the pop strobe
  logic [W-1:0] q_data [16];
  logic [7:0]   q_idx  [16];
  int           qn    = 0;
  int           ptr   = 0;
  int           pops  = 0;
  logic         q_clr = 1'b1;

  assign sq_empty = (ptr >= qn);

  always @(posedge clk) begin
    if (q_clr) begin
      ptr  <= 0;
      pops <= 0;
    end else if (sq_rd_en) begin
      sq_rd_data  <= q_data[ptr];
      sq_rd_index <= q_idx[ptr];
      ptr         <= ptr + 1;
      pops        <= pops + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] idx, input logic [W-1:0] d);
    q_data[qn] = d;
    q_idx[qn]  = idx;
    qn         = qn + 1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " sq_rd_en"}, 64'(sq_rd_en), 0);
    chk({tag, " cmd_valid"}, 64'(cmd_valid), 0);
    chk({tag, " cmd_out"}, cmd_out, 0);
    chk({tag, " cmd_index"}, 64'(cmd_index), 0);
    chk({tag, " status_en"}, 64'(status_update_enable), 0);
    chk({tag, " status_index"}, 64'(status_index), 0);
    chk({tag, " status_code"}, 64'(status_code), 0);
    chk({tag, " outstanding"}, 64'(outstanding), 0);
    chk({tag, " underflow"}, 64'(underflow_err), 0);
  endtask

  typedef struct {
    logic       dv;
    logic [7:0] di;
    logic [7:0] ds;
    logic [3:0] out;
    logic       en;
    logic [7:0] si;
    logic [7:0] sc;
    logic       uf;
  } vec_t;

  vec_t vt [8];
  logic [W-1:0] d06;

  initial begin
    vt[0] = '{1'b1, 8'h01, 8'h10, 4'd2, 1'b1, 8'h01, 8'h10, 1'b0};
    vt[1] = '{1'b1, 8'h02, 8'h20, 4'd1, 1'b1, 8'h02, 8'h20, 1'b0};
    vt[2] = '{1'b0, 8'h00, 8'h00, 4'd1, 1'b0, 8'h02, 8'h20, 1'b0};
    vt[3] = '{1'b1, 8'h03, 8'h30, 4'd0, 1'b1, 8'h03, 8'h30, 1'b0};
    vt[4] = '{1'b1, 8'h1F, 8'h02, 4'd0, 1'b1, 8'h1F, 8'h02, 1'b1};
    vt[5] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 8'h1F, 8'h02, 1'b1};
    vt[6] = '{1'b1, 8'h04, 8'h05, 4'd0, 1'b1, 8'h04, 8'h05, 1'b1};
    vt[7] = '{1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 8'h04, 8'h05, 1'b1};

    d06         = 64'h1234_5678_9ABC_DEF0;
    rst_n       = 1'b0;
    cmd_ready   = 1'b1;
    done_valid  = 1'b0;
    done_index  = '0;
    done_status = '0;
    push(8'h05, 64'hA5A5_A5A5_A5A5_A5A5);
    tick();
    tick();
    q_clr = 1'b0;
    chk_reset("reset");

    // Single command: FETCH, LATCH, PRESENT, accept
    rst_n = 1'b1;
    tick();
    chk("single rd_en", 64'(sq_rd_en), 1);
    chk("single valid early", 64'(cmd_valid), 0);
    tick();
    chk("single rd_en once", 64'(sq_rd_en), 0);
    tick();
    chk("single valid", 64'(cmd_valid), 1);
    chk("single index", 64'(cmd_index), 64'h05);
    chk("single data", cmd_out, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("single out pre", 64'(outstanding), 0);
    tick();
    chk("single valid drop", 64'(cmd_valid), 0);
    chk("single out", 64'(outstanding), 1);
    chk("single pops", 64'(pops), 1);

    // Backpressure for 10 cycles, second entry queued behind
    cmd_ready = 1'b0;
    push(8'h06, d06);
    push(8'h07, 64'h0707_0707_0707_0707);
    tick();
    chk("bp rd_en", 64'(sq_rd_en), 1);
    tick();
    tick();
    chk("bp valid", 64'(cmd_valid), 1);
    chk("bp index", 64'(cmd_index), 64'h06);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp hold valid %0d", i), 64'(cmd_valid), 1);
      chk($sformatf("bp hold data %0d", i), cmd_out, d06);
      chk($sformatf("bp pops %0d", i), 64'(pops), 2);
    end
    cmd_ready = 1'b1;
    tick();
    chk("bp accept valid", 64'(cmd_valid), 0);
    chk("bp accept out", 64'(outstanding), 2);
    for (int i = 0; i < 10 && outstanding != 4'd3; i++) tick();
    chk("bp second issued", 64'(outstanding), 3);

    // Handshake and completion in the same cycle
    cmd_ready = 1'b0;
    push(8'h08, 64'h0808);
    for (int i = 0; i < 10 && !cmd_valid; i++) tick();
    chk("sim valid", 64'(cmd_valid), 1);
    cmd_ready   = 1'b1;
    done_valid  = 1'b1;
    done_index  = 8'h0A;
    done_status = 8'h33;
    tick();
    done_valid = 1'b0;
    chk("sim out", 64'(outstanding), 3);
    chk("sim en", 64'(status_update_enable), 1);
    chk("sim idx", 64'(status_index), 64'h0A);
    chk("sim code", 64'(status_code), 64'h33);
    tick();
    chk("sim en drop", 64'(status_update_enable), 0);
    chk("sim out hold", 64'(outstanding), 3);

    // Completion table, including underflow
    for (int i = 0; i < 8; i++) begin
      done_valid  = vt[i].dv;
      done_index  = vt[i].di;
      done_status = vt[i].ds;
      tick();
      chk($sformatf("vec%0d out", i), 64'(outstanding), 64'(vt[i].out));
      chk($sformatf("vec%0d en", i), 64'(status_update_enable),
          64'(vt[i].en));
      chk($sformatf("vec%0d idx", i), 64'(status_index), 64'(vt[i].si));
      chk($sformatf("vec%0d code", i), 64'(status_code), 64'(vt[i].sc));
      chk($sformatf("vec%0d uf", i), 64'(underflow_err), 64'(vt[i].uf));
    end
    done_valid = 1'b0;

    // Credit limit: 10 queued, no completions
    rst_n = 1'b0;
    q_clr = 1'b1;
    qn    = 0;
    for (int i = 0; i < 10; i++) push(8'(8'h20 + i), 64'(i));
    tick();
    q_clr = 1'b0;
    chk("credit reset uf", 64'(underflow_err), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 45; i++) tick();
    chk("credit pops", 64'(pops), 8);
    chk("credit out", 64'(outstanding), 8);
    chk("credit idle valid", 64'(cmd_valid), 0);
    chk("credit idle rd_en", 64'(sq_rd_en), 0);
    chk("credit nonempty", 64'(sq_empty), 0);
    done_valid = 1'b1;
    done_index = 8'h21;
    tick();
    done_valid = 1'b0;
    chk("credit out dec", 64'(outstanding), 7);
    chk("credit rd_en not yet", 64'(sq_rd_en), 0);
    tick();
    chk("credit rd_en resume", 64'(sq_rd_en), 1);
    tick();
    chk("credit pops 9", 64'(pops), 9);

    // Asynchronous reset while presenting with two outstanding
    rst_n = 1'b0;
    q_clr = 1'b1;
    qn    = 0;
    for (int i = 0; i < 3; i++) push(8'(8'h40 + i), 64'(64'h100 + i));
    tick();
    q_clr = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20 && outstanding != 4'd2; i++) tick();
    cmd_ready = 1'b0;
    chk("rst out two", 64'(outstanding), 2);
    for (int i = 0; i < 10 && !cmd_valid; i++) tick();
    chk("rst presenting", 64'(cmd_valid), 1);
    chk("rst index", 64'(cmd_index), 64'h42);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    push(8'h43, 64'h103);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart rd_en", 64'(sq_rd_en), 1);
    tick();
    tick();
    chk("restart index", 64'(cmd_index), 64'h43);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
